// File: rtl/traffic_pkg.sv
// Shared types and constants for the highway / farm-road intersection controller.
package traffic_pkg;

    // Controller states: which road holds right of way and in which phase
    typedef enum logic [1:0] {
        HGRE_FRED = 2'd0,
        HYEL_FRED = 2'd1,
        HRED_FGRE = 2'd2,
        HRED_FYEL = 2'd3
    } state_e;

    // One-hot signal-head codes
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

endpackage

// File: rtl/traffic_light_tick_gen.sv
// Clock divider plus tick counter. Both clear together so every dwell
// starts from a known phase; done_o pulses on the cycle whose edge would
// bring the tick count up to target_i.
module tick_gen #(
    parameter int TICK_DIV = 10,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] target_i,
    output logic             done_o
);

    // A one-cycle divider still needs one register bit
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    assign tick   = (div_q == DIV_LAST);
    assign done_o = tick && (cnt_q == (target_i - CNT_W'(1)));

    // Next-state for divider (wraps to emit ticks) and tick counter (saturates)
    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            div_d = '0;
            cnt_d = '0;
        end else begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter registers with asynchronous clear on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_light.sv
// Highway / farm-road intersection controller: Moore FSM, highway green by
// default, farm sensor launches a fixed-duration yellow/green/yellow cycle.
// Note: rst_n is active-high despite its name.
module traffic_light
    import traffic_pkg::*;
#(
    parameter int TICK_DIV   = 10,
    parameter int YEL_TICKS  = 3,
    parameter int FGRN_TICKS = 10
) (
    output logic [2:0] light_highway,
    output logic [2:0] light_farm,
    input  logic       sensor,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int MAX_TICKS = (YEL_TICKS > FGRN_TICKS) ? YEL_TICKS : FGRN_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS + 1) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] target;
    logic             clr;
    logic             done;

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst_n),
        .clr_i    (clr),
        .target_i (target),
        .done_o   (done)
    );

    // Next-state logic and dwell target for the current state
    always_comb begin
        state_d = state_q;
        target  = CNT_W'(YEL_TICKS);
        case (state_q)
            HGRE_FRED: if (sensor) state_d = HYEL_FRED;
            HYEL_FRED: if (done)   state_d = HRED_FGRE;
            HRED_FGRE: begin
                target = CNT_W'(FGRN_TICKS);
                if (done) state_d = HRED_FYEL;
            end
            HRED_FYEL: if (done)   state_d = HGRE_FRED;
            default:   state_d = HGRE_FRED;
        endcase
    end

    // Restart timing on every state change so dwell is phase-independent
    assign clr = (state_d != state_q);

    // State register, asynchronous reset to highway green
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= HGRE_FRED;
        end else begin
            state_q <= state_d;
        end
    end

    // Signal heads decoded from state alone
    always_comb begin
        light_highway = GREEN;
        light_farm    = RED;
        case (state_q)
            HGRE_FRED: begin light_highway = GREEN;  light_farm = RED;    end
            HYEL_FRED: begin light_highway = YELLOW; light_farm = RED;    end
            HRED_FGRE: begin light_highway = RED;    light_farm = GREEN;  end
            HRED_FYEL: begin light_highway = RED;    light_farm = YELLOW; end
            default:   begin light_highway = GREEN;  light_farm = RED;    end
        endcase
    end

endmodule

// File: tb/tb_traffic_light.sv
// Testbench for traffic_light with default parameters (30/100/30 cycle dwells).
module tb_traffic_light;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;
    localparam int YEL_CYC  = 30;
    localparam int FGRN_CYC = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sensor = 1'b0;
    logic [2:0] hwy, farm;

    int total = 0;
    int bad   = 0;

    int mstate = 0;
    int mcnt   = 0;
    logic [5:0] sb[$];

    typedef struct {
        bit         sens;
        int         cycles;
        logic [2:0] hwy;
        logic [2:0] farm;
    } seg_t;

    seg_t tbl[13];

    traffic_light #(
        .TICK_DIV   (10),
        .YEL_TICKS  (3),
        .FGRN_TICKS (10)
    ) dut (
        .light_highway (hwy),
        .light_farm    (farm),
        .sensor        (sensor),
        .clk           (clk),
        .rst_n         (rst_n)
    );

    always #10 clk = ~clk;

    function automatic logic [5:0] model_out(input int st);
        case (st)
            0:       return {G, R};
            1:       return {Y, R};
            2:       return {R, G};
            default: return {R, Y};
        endcase
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got hwy=%b farm=%b, expected hwy=%b farm=%b",
                     name, act[5:3], act[2:0], exp[5:3], exp[2:0]);
        end
    endtask

    // One clock cycle: drive sensor, advance the reference model, compare after the edge
    task automatic step(input bit s);
        logic [5:0] exp;
        bit ok;
        @(negedge clk);
        sensor = s;
        if (mstate == 0) begin
            if (s) begin mstate = 1; mcnt = 0; end
        end else begin
            mcnt++;
            if (mcnt == ((mstate == 2) ? FGRN_CYC : YEL_CYC)) begin
                mstate = (mstate + 1) % 4;
                mcnt = 0;
            end
        end
        sb.push_back(model_out(mstate));
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        check("seq", {hwy, farm}, exp);
        ok = $onehot(hwy) && $onehot(farm) && ((hwy == R) || (farm == R));
        check("safety", {5'b0, ok}, 6'd1);
    endtask

    initial begin
        tbl[0]  = '{0, 300, G, R};
        tbl[1]  = '{1, 1,   Y, R};
        tbl[2]  = '{1, 29,  Y, R};
        tbl[3]  = '{1, 1,   R, G};
        tbl[4]  = '{0, 99,  R, G};
        tbl[5]  = '{1, 1,   R, Y};
        tbl[6]  = '{0, 29,  R, Y};
        tbl[7]  = '{1, 1,   G, R};
        tbl[8]  = '{1, 1,   Y, R};
        tbl[9]  = '{0, 30,  R, G};
        tbl[10] = '{0, 100, R, Y};
        tbl[11] = '{0, 30,  G, R};
        tbl[12] = '{0, 50,  G, R};

        // Reset held 20 cycles
        #1;
        check("reset_t0", {hwy, farm}, {G, R});
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", {hwy, farm}, {G, R});
        end
        @(negedge clk);
        rst_n = 1'b0;
        mstate = 0;
        mcnt = 0;

        // Table of segments with end-of-segment expectations
        for (int i = 0; i < 13; i++) begin
            repeat (tbl[i].cycles) step(tbl[i].sens);
            check($sformatf("tbl%0d", i), {hwy, farm}, {tbl[i].hwy, tbl[i].farm});
        end

        // Single-cycle pulse: one full sequence then hold
        step(1'b1);
        repeat (170) step(1'b0);
        check("pulse_end", {hwy, farm}, {G, R});

        // Sensor toggled throughout the sequence
        step(1'b1);
        repeat (200) step(1'($urandom_range(0, 1)));
        repeat (200) step(1'b0);
        check("toggle_end", {hwy, farm}, {G, R});

        // Asynchronous reset in the middle of farm green
        step(1'b1);
        repeat (40) step(1'b0);
        check("pre_reset_fgre", {hwy, farm}, {R, G});
        #5;
        rst_n = 1'b1;
        #1;
        check("async_reset", {hwy, farm}, {G, R});
        mstate = 0;
        mcnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (50) step(1'b0);
        check("after_reset", {hwy, farm}, {G, R});

        // Long run with safety checks every cycle
        repeat (300) step(1'b0);
        repeat (600) step(1'b1);
        repeat (600) step(1'b0);
        repeat (10) step(1'b1);
        check("long_end", {hwy, farm}, {Y, R});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
